// File: rtl/axi_to_mem_pkg.sv
// Shared definitions for the stream-to-memory adapter.
// Holds the credit-counter width helper and the legal response-buffer depth range.
// No logic; imported by the adapter top and its buffer.
package axi_to_mem_pkg;

    localparam int unsigned BufDepthMin = 1;
    localparam int unsigned BufDepthMax = 16;

    // Width needed to count 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO used as the response buffer.
// Latency: data pushed in cycle N is visible at the head from cycle N+1.
// Backpressure: none internally; caller guarantees no push while full unless popping.
module stream_fifo
    import axi_to_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = cnt_width(DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]       r_wptr;
    logic [PtrW-1:0]       r_rptr;
    logic [CntW-1:0]       r_cnt;
    logic                  w_push;
    logic                  w_pop;

    assign empty_o = (r_cnt == '0);
    assign full_o  = (r_cnt == CntW'(DEPTH));
    assign data_o  = r_mem[r_rptr];

    // A push while full is legal only when the head leaves in the same cycle.
    assign w_push = push_i & (~full_o | pop_i);
    assign w_pop  = pop_i & ~empty_o;

    // Storage write; cleared on reset so stale data never resurfaces.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping with wrap at DEPTH-1 (depth need not be a power of two).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - CntW'(1);
            end
        end
    end

    // Overflow would mean the credit scheme upstream is broken.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/stream_to_mem.sv
// Credit-limited bridge from a request stream to a fixed-order memory port.
// Latency: request passes through combinationally; response falls through in 0 cycles when unbuffered.
// Backpressure: requester stalls combinationally on mem_req_ready_i low or when all credits are in use.
module stream_to_mem
    import axi_to_mem_pkg::*;
#(
    parameter int unsigned ReqWidth  = 8,
    parameter int unsigned RespWidth = 8,
    parameter int unsigned BufDepth  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [ReqWidth-1:0]  req_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [RespWidth-1:0] resp_o,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [ReqWidth-1:0]  mem_req_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    input  logic [RespWidth-1:0] mem_resp_i,
    input  logic                 mem_resp_valid_i
);

    localparam int unsigned CntW = cnt_width(BufDepth);

    if (BufDepth < BufDepthMin || BufDepth > BufDepthMax) begin : g_bad_depth
        $error("stream_to_mem: BufDepth out of range");
    end

    // Credits in use: issued requests whose response has not yet left on resp_o.
    logic [CntW-1:0]      cnt_q;
    logic                 w_credit_ok;
    logic                 w_issue;
    logic                 w_drain;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [RespWidth-1:0] w_head;

    // Request path is pure wiring plus the credit gate: nothing is held here.
    assign w_credit_ok     = (cnt_q < CntW'(BufDepth));
    assign mem_req_o       = req_i;
    assign mem_req_valid_o = req_valid_i & w_credit_ok;
    assign req_ready_o     = mem_req_ready_i & w_credit_ok;

    // Buffered data always goes first to keep responses in request order.
    assign resp_valid_o = ~w_empty | mem_resp_valid_i;
    assign resp_o       = !w_empty        ? w_head     :
                          mem_resp_valid_i ? mem_resp_i : '0;

    assign w_issue = mem_req_valid_o & mem_req_ready_i;
    assign w_drain = resp_valid_o & resp_ready_i;
    assign w_push  = mem_resp_valid_i & ~(w_empty & resp_ready_i);
    assign w_pop   = w_drain & ~w_empty;

    stream_fifo #(
        .DATA_WIDTH (RespWidth),
        .DEPTH      (BufDepth)
    ) u_resp_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (mem_resp_i),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Credit counter: +1 per issued request, -1 per delivered response, hold when both.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (w_issue && !w_drain) begin
            cnt_q <= cnt_q + CntW'(1);
        end else if (!w_issue && w_drain) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    // Memory must never answer a request that was not issued.
    assert property (@(posedge clk_i) disable iff (!rst_ni) mem_resp_valid_i |-> (cnt_q != '0));

    // A full buffer can only take new data while its head leaves.
    assert property (@(posedge clk_i) disable iff (!rst_ni) (w_full && w_push) |-> w_pop);

endmodule
